md_operand_queue: RTL and testbench

Parametrised operand staging queue in front of the multiply/divide unit, successor to the single-entry operand latch. Holds up to DEPTH pending operations (operand A, operand B, operation control) in FIFO order, with valid/ready handshakes on both sides. An optional write-through bypass forwards an incoming operation to the unit in the same cycle when the queue is empty. A synchronous flush discards all queued work on pipeline exceptions.

---
 rtl/md_operand_queue.sv | 108 ++++++++++
 tb/tb_md_operand_queue.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/md_operand_queue.sv
// Operand staging FIFO in front of the multiply/divide unit.
// Holds up to DEPTH {A, B, ctrl} operations; optional write-through when empty.
module md_operand_queue #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 2,
  parameter int DEPTH  = 4,
  parameter int BYPASS = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  input  logic [CTRL_W-1:0]      in_ctrl,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_a,
  output logic [WIDTH-1:0]       out_b,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 2 * WIDTH + CTRL_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             bypass_act;
  logic             push, pop;
  logic             wr_en, rd_en;
  logic [ENT_W-1:0] in_ent, head_ent, out_ent;

  // Status and head selection; in_ready is a pure function of the count register.
  always_comb begin
    full       = (count_q == DEPTH_C);
    empty      = (count_q == '0);
    in_ready   = !full;
    count      = count_q;
    bypass_act = (BYPASS != 0) && empty;
    in_ent     = {in_a, in_b, in_ctrl};
    head_ent   = mem_q[rd_ptr_q];
    out_valid  = bypass_act ? in_valid : !empty;
    out_ent    = bypass_act ? in_ent : head_ent;
    pending    = out_valid;
    {out_a, out_b, out_ctrl} = out_ent;
  end

  // An operation consumed straight through the bypass is never stored.
  always_comb begin
    push  = in_valid && in_ready && !flush;
    pop   = out_valid && out_ready && !flush;
    wr_en = push && !(bypass_act && pop);
    rd_en = pop && !bypass_act;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        mem_d[wr_ptr_q] = in_ent;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_md_operand_queue.sv
// Bench for md_operand_queue: table-driven vectors plus a FIFO scoreboard,
// with a second instance built without the bypass.
module tb_md_operand_queue;

  localparam int WIDTH  = 32;
  localparam int CTRL_W = 2;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, flush, in_valid, out_ready;
  logic [WIDTH-1:0]  in_a, in_b;
  logic [CTRL_W-1:0] in_ctrl;

  logic              in_ready, out_valid, full, empty, pending;
  logic [WIDTH-1:0]  out_a, out_b;
  logic [CTRL_W-1:0] out_ctrl;
  logic [2:0]        count;

  logic              in_ready0, out_valid0, full0, empty0, pending0;
  logic [WIDTH-1:0]  out_a0, out_b0;
  logic [CTRL_W-1:0] out_ctrl0;
  logic [2:0]        count0;

  md_operand_queue #(.WIDTH(WIDTH), .CTRL_W(CTRL_W), .DEPTH(DEPTH), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b), .out_ctrl(out_ctrl),
    .count(count), .full(full), .empty(empty), .pending(pending)
  );

  md_operand_queue #(.WIDTH(WIDTH), .CTRL_W(CTRL_W), .DEPTH(DEPTH), .BYPASS(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_a(in_a), .in_b(in_b), .in_ctrl(in_ctrl),
    .out_valid(out_valid0), .out_ready(out_ready), .out_a(out_a0), .out_b(out_b0), .out_ctrl(out_ctrl0),
    .count(count0), .full(full0), .empty(empty0), .pending(pending0)
  );

  typedef struct {
    logic        v;
    logic [31:0] a;
    logic        r;
    logic        f;
    int          cnt;
    logic        rdy;
  } vec_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  c;
  } op_t;

  vec_t vecs[$];
  op_t  sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bval(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic void addv(input logic v, input logic [31:0] a, input logic r,
                               input logic f, input int cnt, input logic rdy);
    vec_t x;
    x.v = v; x.a = a; x.r = r; x.f = f; x.cnt = cnt; x.rdy = rdy;
    vecs.push_back(x);
  endfunction

  // Drives one cycle from the falling edge, then checks 1 time unit before the rising edge.
  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] c, input logic r, input logic f);
    op_t e;
    logic exp_ov;
    @(negedge clk);
    in_valid = v; in_a = a; in_b = b; in_ctrl = c; out_ready = r; flush = f;
    #4;
    exp_ov = (sb.size() > 0) || v;
    chk("out_valid", out_valid, exp_ov);
    chk("pending", pending, exp_ov);
    if (v && !f && sb.size() < DEPTH) begin
      e.a = a; e.b = b; e.c = c;
      sb.push_back(e);
    end
    if (exp_ov && r && !f) begin
      e = sb.pop_front();
      chk("out_a", out_a, e.a);
      chk("out_b", out_b, e.b);
      chk("out_ctrl", out_ctrl, e.c);
    end
    if (f) sb.delete();
  endtask

  task automatic apply_vec(input vec_t x);
    drive(x.v, x.a, bval(x.a), x.a[1:0], x.r, x.f);
    chk("count", count, x.cnt);
    chk("in_ready", in_ready, x.rdy);
    chk("full", full, (x.cnt == DEPTH));
    chk("empty", empty, (x.cnt == 0));
  endtask

  initial begin
    // Fill to full and drain, with 5 held off until space frees up.
    addv(1, 1, 0, 0, 0, 1);
    addv(1, 2, 0, 0, 1, 1);
    addv(1, 3, 0, 0, 2, 1);
    addv(1, 4, 0, 0, 3, 1);
    addv(1, 5, 0, 0, 4, 0);
    addv(1, 5, 1, 0, 4, 0);
    addv(1, 5, 1, 0, 3, 1);
    addv(0, 0, 1, 0, 3, 1);
    addv(0, 0, 1, 0, 2, 1);
    addv(0, 0, 1, 0, 1, 1);
    addv(0, 0, 1, 0, 0, 1);
    // Steady push/pop at count 2 across several pointer wraps.
    addv(1, 100, 0, 0, 0, 1);
    addv(1, 101, 0, 0, 1, 1);
    for (int i = 0; i < 10; i++) addv(1, 102 + i, 1, 0, 2, 1);
    addv(0, 0, 1, 0, 2, 1);
    addv(0, 0, 1, 0, 1, 1);
    // Flush at count 3 with both handshakes active, then a fresh push.
    addv(1, 200, 0, 0, 0, 1);
    addv(1, 201, 0, 0, 1, 1);
    addv(1, 202, 0, 0, 2, 1);
    addv(1, 299, 1, 1, 3, 1);
    addv(0, 0, 0, 0, 0, 1);
    addv(1, 42, 0, 0, 0, 1);
    addv(0, 0, 1, 0, 1, 1);
    addv(0, 0, 0, 0, 0, 1);

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_ctrl = '0;
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_count", count, 3'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    in_valid = 1'b1; in_a = 32'd55;
    #1;
    chk("rst_bypass_valid", out_valid, 1'b1);
    chk("rst_bypass_a", out_a, 32'd55);
    chk("rst_nobypass_valid", out_valid0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Same-cycle bypass.
    drive(1, 7, 3, 2'b10, 1, 0);
    chk("byp_a", out_a, 32'd7);
    chk("byp_b", out_b, 32'd3);
    chk("byp_ctrl", out_ctrl, 2'b10);
    chk("byp_valid", out_valid, 1'b1);
    drive(0, 0, 0, 2'b00, 0, 0);
    chk("byp_count", count, 3'd0);

    foreach (vecs[i]) apply_vec(vecs[i]);

    // Asynchronous reset with three entries queued.
    for (int i = 0; i < 3; i++) drive(1, 300 + i, bval(300 + i), 2'b01, 0, 0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("pre_rst_count", count, 3'd3);
    #1 reset = 1'b0;
    #1;
    chk("async_rst_count", count, 3'd0);
    chk("async_rst_empty", empty, 1'b1);
    chk("async_rst_in_ready", in_ready, 1'b1);
    chk("async_rst_out_valid", out_valid, 1'b0);
    chk("async_rst_count0", count0, 3'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;

    // Registered-only instance: one cycle of latency.
    drive(1, 9, 32'd11, 2'b11, 0, 0);
    chk("nb_valid_push_cycle", out_valid0, 1'b0);
    drive(0, 0, 0, 2'b00, 1, 0);
    chk("nb_valid_after", out_valid0, 1'b1);
    chk("nb_a_after", out_a0, 32'd9);
    chk("nb_ctrl_after", out_ctrl0, 2'b11);
    chk("nb_count_after", count0, 3'd1);
    drive(0, 0, 0, 2'b00, 0, 0);
    chk("nb_count_drained", count0, 3'd0);
    chk("nb_empty_drained", empty0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
